// File: rtl/music_box_song_player.sv
// N-channel ROM-driven song sequencer: fetches per-step freq/amp words into shadow
// registers, commits them atomically, and mixes generator samples into one DAC sample.
module music_box_song_player #(
    parameter int CHANNELS       = 3,
    parameter int FREQ_W         = 14,
    parameter int AMP_W          = 8,
    parameter int OUT_W          = 8,
    parameter int ROM_AW         = 16,
    parameter int ROM_LAT        = 1,
    parameter int SONG_STEPS     = 184,
    parameter int STEP_MS        = 50,
    parameter int SKIP_MIN_STEPS = 20,
    parameter int STATE_ID       = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [4:0]                   current_state,
    input  logic                         ms_tick,
    input  logic                         loop_en,
    input  logic                         skip_req,
    output logic [ROM_AW-1:0]            rom_addr,
    input  logic [15:0]                  rom_data,
    output logic [CHANNELS*FREQ_W-1:0]   chan_freq,
    output logic [CHANNELS*AMP_W-1:0]    chan_amp,
    input  logic [CHANNELS*AMP_W-1:0]    gen_sample,
    output logic [OUT_W-1:0]             audio_out,
    output logic                         state_complete,
    output logic [15:0]                  step_index
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_COMMIT = 3'd2;
    localparam logic [2:0] S_PLAY   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int WORDS = 2 * CHANNELS;
    localparam int KW    = $clog2(WORDS);
    localparam int LW    = $clog2(ROM_LAT + 1);
    localparam int MSW   = $clog2(STEP_MS + 1);
    localparam int MAXW  = (OUT_W > AMP_W) ? OUT_W : AMP_W;
    localparam int SUM_W = MAXW + $clog2(CHANNELS);

    localparam logic [4:0]       ACTIVE_ID = 5'(STATE_ID);
    localparam logic [15:0]      LAST_STEP = 16'(SONG_STEPS - 1);
    localparam logic [15:0]      SKIP_MIN  = 16'(SKIP_MIN_STEPS);
    localparam logic [MSW-1:0]   MS_LAST   = MSW'(STEP_MS - 1);
    localparam logic [KW-1:0]    K_LAST    = KW'(WORDS - 1);
    localparam logic [LW-1:0]    LAT_LAST  = LW'(ROM_LAT);
    localparam logic [SUM_W-1:0] SAT_MAX   = SUM_W'((64'd1 << OUT_W) - 64'd1);

    logic [2:0]        state, state_nxt;
    logic [15:0]       step, step_nxt;
    logic [MSW-1:0]    ms;
    logic [KW-1:0]     word_k;
    logic [LW-1:0]     wait_cnt;
    logic [FREQ_W-1:0] sh_freq [CHANNELS];
    logic [AMP_W-1:0]  sh_amp  [CHANNELS];
    logic              output_active, act_nxt;
    logic              in_state, capture, last_word, boundary, skip_ok;
    logic [ROM_AW-1:0] base_addr;
    logic [SUM_W-1:0]  mix_sum;
    logic [OUT_W-1:0]  mix_sat;
    logic              unused_rom;

    assign unused_rom = ^rom_data;
    assign step_index = step;

    always_comb begin
        in_state  = (current_state == ACTIVE_ID);
        capture   = (state == S_FETCH) && (wait_cnt == LAT_LAST);
        last_word = (word_k == K_LAST);
        boundary  = (state == S_PLAY) && ms_tick && (ms == MS_LAST);
        skip_ok   = skip_req && (step >= SKIP_MIN) &&
                    ((state == S_FETCH) || (state == S_COMMIT) || (state == S_PLAY));
        state_nxt = state;
        step_nxt  = step;
        case (state)
            S_IDLE: begin
                if (in_state) begin
                    state_nxt = S_FETCH;
                    step_nxt  = '0;
                end
            end
            S_FETCH: begin
                if (capture && last_word) state_nxt = S_COMMIT;
            end
            S_COMMIT: state_nxt = S_PLAY;
            S_PLAY: begin
                if (boundary) begin
                    if (step != LAST_STEP) begin
                        step_nxt  = step + 16'd1;
                        state_nxt = S_FETCH;
                    end else if (loop_en) begin
                        step_nxt  = '0;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        // Skip outranks the step boundary; leaving the controller state outranks both.
        if (skip_ok) begin
            state_nxt = S_DONE;
            step_nxt  = step;
        end
        if (!in_state) begin
            state_nxt = S_IDLE;
            step_nxt  = '0;
        end
        act_nxt = output_active;
        if (state == S_COMMIT) act_nxt = 1'b1;
        if ((state_nxt == S_IDLE) || (state_nxt == S_DONE)) act_nxt = 1'b0;
        base_addr = ROM_AW'(32'(step_nxt) * 32'(WORDS));
    end

    always_comb begin
        mix_sum = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            mix_sum = mix_sum + SUM_W'(gen_sample[i*AMP_W +: AMP_W]);
        end
        mix_sat = (mix_sum > SAT_MAX) ? '1 : OUT_W'(mix_sum);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            step           <= '0;
            ms             <= '0;
            word_k         <= '0;
            wait_cnt       <= '0;
            output_active  <= 1'b0;
            rom_addr       <= '0;
            chan_freq      <= '0;
            chan_amp       <= '0;
            audio_out      <= '0;
            state_complete <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                sh_freq[i] <= '0;
                sh_amp[i]  <= '0;
            end
        end else begin
            state          <= state_nxt;
            step           <= step_nxt;
            output_active  <= act_nxt;
            audio_out      <= act_nxt ? mix_sat : '0;
            state_complete <= (state_nxt == S_DONE);
            if ((state_nxt == S_IDLE) || (state_nxt == S_DONE)) begin
                chan_freq <= '0;
                chan_amp  <= '0;
                ms        <= '0;
                word_k    <= '0;
                wait_cnt  <= '0;
            end else if ((state_nxt == S_FETCH) && (state != S_FETCH)) begin
                rom_addr <= base_addr;
                word_k   <= '0;
                wait_cnt <= '0;
                ms       <= '0;
            end else begin
                case (state)
                    S_FETCH: begin
                        if (capture) begin
                            for (int unsigned i = 0; i < CHANNELS; i++) begin
                                if (word_k == KW'(2 * i))     sh_freq[i] <= rom_data[FREQ_W-1:0];
                                if (word_k == KW'(2 * i + 1)) sh_amp[i]  <= rom_data[AMP_W-1:0];
                            end
                            wait_cnt <= '0;
                            if (!last_word) begin
                                word_k   <= word_k + KW'(1);
                                rom_addr <= rom_addr + ROM_AW'(1);
                            end
                        end else begin
                            wait_cnt <= wait_cnt + LW'(1);
                        end
                    end
                    S_COMMIT: begin
                        for (int unsigned i = 0; i < CHANNELS; i++) begin
                            chan_freq[i*FREQ_W +: FREQ_W] <= sh_freq[i];
                            chan_amp[i*AMP_W +: AMP_W]    <= sh_amp[i];
                        end
                        ms <= '0;
                    end
                    S_PLAY: begin
                        if (ms_tick) ms <= ms + MSW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_music_box_song_player.sv
// Directed bench: default-parameter player plus a 4-step, 2-ms player for end-of-song
// and loop behaviour; ROM models return word i = i after one cycle.
module tb_music_box_song_player;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ms_tick, loop_en, skip_req;
    logic [23:0] gen_sample;

    logic [4:0]  cs_a, cs_b;
    logic [15:0] rom_addr_a, rom_addr_b;
    logic [15:0] rom_data_a = '0, rom_data_b = '0;
    logic [41:0] chan_freq_a, chan_freq_b;
    logic [23:0] chan_amp_a, chan_amp_b;
    logic [7:0]  audio_a, audio_b;
    logic        done_a, done_b;
    logic [15:0] step_a, step_b;

    int errors = 0;
    int checks = 0;
    int seen;

    always #10 clk = ~clk;

    always @(posedge clk) rom_data_a <= rom_addr_a;
    always @(posedge clk) rom_data_b <= rom_addr_b;

    music_box_song_player dut (
        .clk(clk), .reset_n(reset_n), .current_state(cs_a), .ms_tick(ms_tick),
        .loop_en(loop_en), .skip_req(skip_req), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .chan_freq(chan_freq_a), .chan_amp(chan_amp_a), .gen_sample(gen_sample),
        .audio_out(audio_a), .state_complete(done_a), .step_index(step_a)
    );

    music_box_song_player #(.SONG_STEPS(4), .STEP_MS(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .current_state(cs_b), .ms_tick(ms_tick),
        .loop_en(loop_en), .skip_req(skip_req), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .chan_freq(chan_freq_b), .chan_amp(chan_amp_b), .gen_sample(gen_sample),
        .audio_out(audio_b), .state_complete(done_b), .step_index(step_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_step_a(input logic [15:0] target, input int budget);
        for (int n = 0; n < budget && step_a !== target; n++) @(negedge clk);
        check($sformatf("reach_step_%0d", target), 64'(step_a), 64'(target));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; cs_a = 5'd0; cs_b = 5'd0;
        ms_tick = 1'b0; loop_en = 1'b0; skip_req = 1'b0;
        gen_sample = {8'd10, 8'd20, 8'd30};
        repeat (2) @(negedge clk);
        check("rst_rom_addr", 64'(rom_addr_a), 64'd0);
        check("rst_chan_freq", 64'(chan_freq_a), 64'd0);
        check("rst_chan_amp", 64'(chan_amp_a), 64'd0);
        check("rst_audio", 64'(audio_a), 64'd0);
        check("rst_complete", 64'(done_a), 64'd0);
        check("rst_step", 64'(step_a), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Entry: commit lands 13 cycles after the entry edge
        cs_a = 5'd1;
        repeat (13) @(negedge clk);
        check("pre_commit_amp", 64'(chan_amp_a), 64'd0);
        check("pre_commit_audio", 64'(audio_a), 64'd0);
        check("last_word_addr", 64'(rom_addr_a), 64'd5);
        @(negedge clk);
        check("commit_amp", 64'(chan_amp_a), 64'h050301);
        check("commit_freq", 64'(chan_freq_a), 64'({14'd4, 14'd2, 14'd0}));
        check("mix_60", 64'(audio_a), 64'd60);

        // Mixer saturation
        gen_sample = {8'd200, 8'd100, 8'd50}; @(negedge clk);
        check("mix_sat_350", 64'(audio_a), 64'd255);
        gen_sample = {8'd85, 8'd85, 8'd84}; @(negedge clk);
        check("mix_254", 64'(audio_a), 64'd254);
        gen_sample = {8'd85, 8'd85, 8'd86}; @(negedge clk);
        check("mix_sat_256", 64'(audio_a), 64'd255);
        gen_sample = {8'd0, 8'd0, 8'd0}; @(negedge clk);
        check("mix_0", 64'(audio_a), 64'd0);
        gen_sample = {8'd10, 8'd20, 8'd30};

        // Step advance: old tones hold during fetch, change once at commit
        ms_tick = 1'b1;
        wait_step_a(16'd1, 100);
        check("step1_addr", 64'(rom_addr_a), 64'd6);
        check("step1_hold_amp", 64'(chan_amp_a), 64'h050301);
        repeat (12) @(negedge clk);
        check("step1_late_hold", 64'(chan_amp_a), 64'h050301);
        @(negedge clk);
        check("step1_amp", 64'(chan_amp_a), 64'h0B0907);
        check("step1_freq", 64'(chan_freq_a), 64'({14'd10, 14'd8, 14'd6}));
        repeat (49) @(negedge clk);
        check("step1_before_boundary", 64'(step_a), 64'd1);
        @(negedge clk);
        check("step2_at_50_ticks", 64'(step_a), 64'd2);
        check("step2_addr", 64'(rom_addr_a), 64'd12);

        // Skip before the minimum step is ignored; at step 20 it ends the song
        wait_step_a(16'd5, 400);
        skip_req = 1'b1; @(negedge clk); skip_req = 1'b0;
        check("skip_early_ignored", 64'(done_a), 64'd0);
        wait_step_a(16'd20, 1200);
        skip_req = 1'b1; @(negedge clk); skip_req = 1'b0;
        check("skip20_complete", 64'(done_a), 64'd1);
        check("skip20_amp", 64'(chan_amp_a), 64'd0);
        check("skip20_freq", 64'(chan_freq_a), 64'd0);
        check("skip20_audio", 64'(audio_a), 64'd0);
        repeat (5) @(negedge clk);
        check("done_held", 64'(done_a), 64'd1);
        check("done_step", 64'(step_a), 64'd20);
        cs_a = 5'd0; @(negedge clk);
        check("done_exit", 64'(done_a), 64'd0);
        check("done_exit_step", 64'(step_a), 64'd0);

        // Skip coincident with a step boundary (63 cycles after step entry)
        cs_a = 5'd1;
        wait_step_a(16'd21, 1500);
        repeat (62) @(negedge clk);
        skip_req = 1'b1; @(negedge clk); skip_req = 1'b0;
        check("skip_vs_boundary_done", 64'(done_a), 64'd1);
        check("skip_vs_boundary_step", 64'(step_a), 64'd21);

        // Mid-fetch exit and re-entry
        cs_a = 5'd0; @(negedge clk);
        cs_a = 5'd1;
        wait_step_a(16'd1, 100);
        repeat (3) @(negedge clk);
        check("midfetch_amp", 64'(chan_amp_a), 64'h050301);
        cs_a = 5'd0; @(negedge clk);
        check("exit_amp", 64'(chan_amp_a), 64'd0);
        check("exit_freq", 64'(chan_freq_a), 64'd0);
        check("exit_audio", 64'(audio_a), 64'd0);
        check("exit_complete", 64'(done_a), 64'd0);
        check("exit_step", 64'(step_a), 64'd0);
        cs_a = 5'd1; @(negedge clk);
        check("reentry_step", 64'(step_a), 64'd0);
        check("reentry_addr", 64'(rom_addr_a), 64'd0);
        repeat (13) @(negedge clk);
        check("reentry_amp", 64'(chan_amp_a), 64'h050301);

        // Asynchronous reset mid-play
        repeat (5) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_amp", 64'(chan_amp_a), 64'd0);
        check("async_rst_freq", 64'(chan_freq_a), 64'd0);
        check("async_rst_audio", 64'(audio_a), 64'd0);
        check("async_rst_addr", 64'(rom_addr_a), 64'd0);
        check("async_rst_step", 64'(step_a), 64'd0);
        cs_a = 5'd0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Short song, no loop: completes on the 8th play tick (60 cycles after entry)
        loop_en = 1'b0;
        cs_b = 5'd1;
        repeat (60) @(negedge clk);
        check("short_pre_done", 64'(done_b), 64'd0);
        check("short_last_step", 64'(step_b), 64'd3);
        @(negedge clk);
        check("short_done", 64'(done_b), 64'd1);
        check("short_done_audio", 64'(audio_b), 64'd0);
        check("short_done_amp", 64'(chan_amp_b), 64'd0);
        repeat (4) @(negedge clk);
        check("short_done_held", 64'(done_b), 64'd1);
        cs_b = 5'd0; @(negedge clk);
        check("short_done_fall", 64'(done_b), 64'd0);

        // Short song, looping: wraps to step 0 and never completes
        loop_en = 1'b1;
        cs_b = 5'd1;
        repeat (60) @(negedge clk);
        check("loop_last_step", 64'(step_b), 64'd3);
        @(negedge clk);
        check("loop_wrap_step", 64'(step_b), 64'd0);
        check("loop_wrap_addr", 64'(rom_addr_b), 64'd0);
        check("loop_no_done", 64'(done_b), 64'd0);
        check("loop_hold_amp", 64'(chan_amp_b), 64'h171513);
        repeat (13) @(negedge clk);
        check("loop_recommit_amp", 64'(chan_amp_b), 64'h050301);
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done_b) seen++;
        end
        check("loop_never_done", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
